// File: rtl/arbitro_registro_if.sv
// Bus between the requesters and the shared-register arbiter.
// 'master' is the requester side, 'slave' is the arbiter side.
interface arbitro_registro_if #(
  parameter int unsigned ANCHO = 4
);
  logic [3:0]         Solicitud;
  logic [4*ANCHO-1:0] Datos;
  logic [3:0]         Concesion;
  logic               Habilitar;
  logic [ANCHO-1:0]   Tupla;
  logic [3:0]         Hecho;
  logic               Ocupado;

  modport master (
    output Solicitud, Datos,
    input  Concesion, Habilitar, Tupla, Hecho, Ocupado
  );

  modport slave (
    input  Solicitud, Datos,
    output Concesion, Habilitar, Tupla, Hecho, Ocupado
  );
endinterface

// File: rtl/arbitro_registro.sv
// Four-requester arbiter for one shared register: grant, one write cycle, then RETENCION hold cycles.
// Round-robin by default; define ARBITRO_PRIORIDAD_FIJA_EN for fixed lowest-index-first priority.
module arbitro_registro #(
  parameter int unsigned ANCHO     = 4,
  parameter int unsigned RETENCION = 1
) (
  input logic                Reloj,
  input logic                Reiniciar,
  arbitro_registro_if.slave  bus
);

  typedef enum logic [1:0] {
    LIBRE    = 2'd0,
    ESCRIBIR = 2'd1,
    RETENER  = 2'd2
  } estado_t;

  localparam logic [3:0] RET_M1 = (RETENCION == 0) ? 4'd0 : 4'(RETENCION - 1);

  estado_t          state_q, state_d;
  logic [3:0]       concesion_q, concesion_d;
  logic             habilitar_q, habilitar_d;
  logic [ANCHO-1:0] tupla_q, tupla_d;
  logic [3:0]       hecho_q, hecho_d;
  logic             ocupado_q, ocupado_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       ptr_q, ptr_d;

  logic [1:0]       ganador;
  logic             hay_solicitud;

  // Winner selection; the pointer remembers the last winner so it gets lowest priority next time.
  always_comb begin
    logic [1:0] idx;
    ganador       = '0;
    hay_solicitud = 1'b0;
    idx           = '0;
`ifdef ARBITRO_PRIORIDAD_FIJA_EN
    for (int unsigned i = 0; i < 4; i++) begin
      idx = 2'(i);
      if (!hay_solicitud && bus.Solicitud[idx]) begin
        ganador       = idx;
        hay_solicitud = 1'b1;
      end
    end
`else
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!hay_solicitud && bus.Solicitud[idx]) begin
        ganador       = idx;
        hay_solicitud = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    concesion_d = concesion_q;
    habilitar_d = habilitar_q;
    tupla_d     = tupla_q;
    hecho_d     = hecho_q;
    ocupado_d   = ocupado_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;

    case (state_q)
      LIBRE: begin
        if (hay_solicitud) begin
          state_d     = ESCRIBIR;
          concesion_d = 4'b0001 << ganador;
          hecho_d     = 4'b0001 << ganador;
          habilitar_d = 1'b1;
          tupla_d     = bus.Datos[ganador*ANCHO +: ANCHO];
          ptr_d       = ganador;
          ocupado_d   = 1'b1;
        end
      end
      ESCRIBIR: begin
        habilitar_d = 1'b0;
        hecho_d     = '0;
        if (RETENCION == 0) begin
          state_d     = LIBRE;
          concesion_d = '0;
          ocupado_d   = 1'b0;
        end else begin
          state_d = RETENER;
          cnt_d   = RET_M1;
        end
      end
      RETENER: begin
        if (cnt_q == '0) begin
          state_d     = LIBRE;
          concesion_d = '0;
          ocupado_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d     = LIBRE;
        concesion_d = '0;
        habilitar_d = 1'b0;
        hecho_d     = '0;
        ocupado_d   = 1'b0;
      end
    endcase
  end

  // Pointer resets to 3 so the first arbitration after reset starts at requester 0.
  always_ff @(posedge Reloj or negedge Reiniciar) begin
    if (!Reiniciar) begin
      state_q     <= LIBRE;
      concesion_q <= '0;
      habilitar_q <= 1'b0;
      tupla_q     <= '0;
      hecho_q     <= '0;
      ocupado_q   <= 1'b0;
      cnt_q       <= '0;
      ptr_q       <= 2'd3;
    end else begin
      state_q     <= state_d;
      concesion_q <= concesion_d;
      habilitar_q <= habilitar_d;
      tupla_q     <= tupla_d;
      hecho_q     <= hecho_d;
      ocupado_q   <= ocupado_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.Concesion = concesion_q;
  assign bus.Habilitar = habilitar_q;
  assign bus.Tupla     = tupla_q;
  assign bus.Hecho     = hecho_q;
  assign bus.Ocupado   = ocupado_q;

endmodule

// File: tb/tb_arbitro_registro.sv
// Bench for arbitro_registro: vector table, hand sequences, then random traffic vs a transaction-level model.
// Two instances: RETENCION=1 (dut0) and RETENCION=0 (dut1), driven with the same requests.
module tb_arbitro_registro;

  logic Reloj = 1'b0;
  logic Reiniciar = 1'b0;
  always #5 Reloj = ~Reloj;

  arbitro_registro_if #(.ANCHO(4)) bus0 ();
  arbitro_registro_if #(.ANCHO(4)) bus1 ();

  assign bus1.Solicitud = bus0.Solicitud;
  assign bus1.Datos     = bus0.Datos;

  arbitro_registro #(.ANCHO(4), .RETENCION(1)) dut0 (
    .Reloj(Reloj), .Reiniciar(Reiniciar), .bus(bus0)
  );
  arbitro_registro #(.ANCHO(4), .RETENCION(0)) dut1 (
    .Reloj(Reloj), .Reiniciar(Reiniciar), .bus(bus1)
  );

  // Observed outputs packed as {Concesion, Habilitar, Tupla, Hecho, Ocupado}
  logic [13:0] out0, out1;
  assign out0 = {bus0.Concesion, bus0.Habilitar, bus0.Tupla, bus0.Hecho, bus0.Ocupado};
  assign out1 = {bus1.Concesion, bus1.Habilitar, bus1.Tupla, bus1.Hecho, bus1.Ocupado};

  int unsigned checks = 0;
  int unsigned errors = 0;

  function automatic logic [13:0] pk(logic [3:0] c, logic h, logic [3:0] t, logic [3:0] hc, logic o);
    return {c, h, t, hc, o};
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got conc=%b hab=%b tupla=%h hecho=%b ocup=%b, expected conc=%b hab=%b tupla=%h hecho=%b ocup=%b",
               name, act[13:10], act[9], act[8:5], act[4:1], act[0],
               exp[13:10], exp[9], exp[8:5], exp[4:1], exp[0]);
    end
  endtask

  // Reference model: a transfer occupies 1+RETENCION cycles after the sampling edge;
  // the first of those is the write cycle.
  int unsigned m_left  [2];
  logic [3:0]  m_grant [2];
  logic [3:0]  m_tupla [2];
  int unsigned m_ptr   [2];

  function automatic int unsigned ret_of(int unsigned d);
    return (d == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_left[d]  = 0;
      m_grant[d] = '0;
      m_tupla[d] = '0;
      m_ptr[d]   = 3;
    end
  endtask

  task automatic model_step(input int unsigned d, input logic [3:0] req, input logic [15:0] dat);
    int w;
    logic [15:0] sh;
    if (m_left[d] == 0) begin
      if (req != 0) begin
        w = -1;
`ifdef ARBITRO_PRIORIDAD_FIJA_EN
        for (int i = 3; i >= 0; i--) if (req[i]) w = i;
`else
        for (int k = 4; k >= 1; k--) if (req[(m_ptr[d] + k) % 4]) w = (m_ptr[d] + k) % 4;
`endif
        m_left[d]  = 1 + ret_of(d);
        m_grant[d] = 4'(1 << w);
        sh         = dat >> (4 * w);
        m_tupla[d] = sh[3:0];
        m_ptr[d]   = w;
      end
    end else begin
      m_left[d] = m_left[d] - 1;
      if (m_left[d] == 0) m_grant[d] = '0;
    end
  endtask

  function automatic logic [13:0] model_out(int unsigned d);
    logic hab;
    hab = (m_left[d] == 1 + ret_of(d));
    return pk(m_grant[d], hab, m_tupla[d], hab ? m_grant[d] : 4'b0000, m_left[d] != 0);
  endfunction

  task automatic do_reset();
    @(posedge Reloj);
    #1 Reiniciar = 1'b0;
    bus0.Solicitud = '0;
    #2;
    check("reset_dut0", out0, '0);
    check("reset_dut1", out1, '0);
    @(posedge Reloj);
    #1 Reiniciar = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] dat;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [3:0] g, t;
    logic [15:0] sh;
    bus0.Solicitud = '0;
    bus0.Datos     = '0;
    model_reset();

    // Single request from requester 2, then one hold cycle, then idle
    tbl.push_back('{1'b1, 4'b0100, 16'h0A00, pk(4'b0100, 1'b1, 4'hA, 4'b0100, 1'b1)});
    tbl.push_back('{1'b0, 4'b0000, 16'h0A00, pk(4'b0100, 1'b0, 4'hA, 4'b0000, 1'b1)});
    tbl.push_back('{1'b0, 4'b0000, 16'h0000, pk(4'b0000, 1'b0, 4'hA, 4'b0000, 1'b0)});
    // All four requesting continuously: one write every 3 cycles
    for (int k = 0; k < 5; k++) begin
`ifdef ARBITRO_PRIORIDAD_FIJA_EN
      g = 4'b0001;
      t = 4'h1;
`else
      g = 4'(1 << (k % 4));
      t = 4'(k % 4 + 1);
`endif
      tbl.push_back('{(k == 0), 4'b1111, 16'h4321, pk(g, 1'b1, t, g, 1'b1)});
      tbl.push_back('{1'b0, 4'b1111, 16'h4321, pk(g, 1'b0, t, 4'b0000, 1'b1)});
      tbl.push_back('{1'b0, 4'b1111, 16'h4321, pk(4'b0000, 1'b0, t, 4'b0000, 1'b0)});
    end

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      bus0.Solicitud = tbl[i].req;
      bus0.Datos     = tbl[i].dat;
      @(posedge Reloj);
      #1 check($sformatf("vec%0d", i), out0, tbl[i].exp);
    end

    // Reset asserted during the write cycle: outputs drop at once, no Hecho afterwards
    do_reset();
    bus0.Solicitud = 4'b1111;
    bus0.Datos     = 16'h4321;
    @(posedge Reloj);
    #1 check("esc_before_rst", out0, pk(4'b0001, 1'b1, 4'h1, 4'b0001, 1'b1));
    #2 Reiniciar = 1'b0;
    #1 check("rst_in_esc_async", out0, '0);
    @(posedge Reloj);
    #1 check("rst_in_esc_held", out0, '0);
    Reiniciar      = 1'b1;
    bus0.Solicitud = 4'b1001;
    @(posedge Reloj);
    #1 check("first_after_rst", out0, pk(4'b0001, 1'b1, 4'h1, 4'b0001, 1'b1));

    // Request withdrawn and data changed during the write cycle
    do_reset();
    bus0.Solicitud = 4'b0010;
    bus0.Datos     = 16'h0050;
    @(posedge Reloj);
    #1 check("drop_esc", out0, pk(4'b0010, 1'b1, 4'h5, 4'b0010, 1'b1));
    bus0.Solicitud = '0;
    bus0.Datos     = 16'hFFFF;
    @(posedge Reloj);
    #1 check("drop_ret", out0, pk(4'b0010, 1'b0, 4'h5, 4'b0000, 1'b1));
    @(posedge Reloj);
    #1 check("drop_libre", out0, pk(4'b0000, 1'b0, 4'h5, 4'b0000, 1'b0));
    @(posedge Reloj);
    #1 check("drop_idle", out0, pk(4'b0000, 1'b0, 4'h5, 4'b0000, 1'b0));

    // Zero hold time with requesters 1 and 3: one write every 2 cycles
    do_reset();
    bus0.Solicitud = 4'b1010;
    bus0.Datos     = 16'h8070;
    for (int k = 0; k < 6; k++) begin
`ifdef ARBITRO_PRIORIDAD_FIJA_EN
      g = 4'b0010;
`else
      g = (k % 2 == 0) ? 4'b0010 : 4'b1000;
`endif
      sh = (g == 4'b0010) ? 16'h0007 : 16'h0008;
      t  = sh[3:0];
      @(posedge Reloj);
      #1 check($sformatf("ret0_w%0d", k), out1, pk(g, 1'b1, t, g, 1'b1));
      @(posedge Reloj);
      #1 check($sformatf("ret0_i%0d", k), out1, pk(4'b0000, 1'b0, t, 4'b0000, 1'b0));
    end

    // Random traffic against the model, both instances
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bus0.Solicitud = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      bus0.Datos     = 16'($urandom);
      @(posedge Reloj);
      model_step(0, bus0.Solicitud, bus0.Datos);
      model_step(1, bus0.Solicitud, bus0.Datos);
      #1;
      check($sformatf("rnd%0d_dut0", n), out0, model_out(0));
      check($sformatf("rnd%0d_dut1", n), out1, model_out(1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/arbitro_registro.md
ARBITRO_REGISTRO -- requirements
Module: arbitro_registro

Interface
REQ-001 Parameter ANCHO, default 4, data width of the shared register.
REQ-002 Parameter RETENCION, default 1, idle cycles the grant is held after each write (0..15).
REQ-003 Reloj  input  1  clock, all state changes on rising edge.
REQ-004 Reiniciar  input  1  reset, asynchronous, active-low.
REQ-005 Solicitud  input  4  write request, one bit per requester 0..3.
REQ-006 Datos  input  4*ANCHO  requester data, requester i on bits [i*ANCHO +: ANCHO].
REQ-007 Concesion  output  4  one-hot grant, 0 when no grant is active.
REQ-008 Habilitar  output  1  write enable to the shared 4-bit register.
REQ-009 Tupla  output  ANCHO  data to the shared register.
REQ-010 Hecho  output  4  one-hot, one-cycle write acknowledge to the granted requester.
REQ-011 Ocupado  output  1  high whenever the state is not LIBRE.

Function
REQ-012 All outputs SHALL be registered; the FSM SHALL have exactly three states: LIBRE, ESCRIBIR and RETENER.
REQ-013 LIBRE, Solicitud==0: stay in LIBRE; Concesion=0, Habilitar=0, Hecho=0.
REQ-014 LIBRE, Solicitud!=0 at edge E: select the winner, load Concesion with its one-hot code, Tupla<=Datos slice of the winner, pointer<=winner, go to ESCRIBIR.
REQ-015 Round-robin: search order is pointer+1, pointer+2, pointer+3, pointer+4 (mod 4); the first set Solicitud bit wins.
REQ-016 ESCRIBIR SHALL last exactly one cycle, with Habilitar=1 and Hecho=Concesion; the register captures Tupla at the closing edge.
REQ-017 From ESCRIBIR: if RETENCION==0, go to LIBRE and clear Concesion; otherwise go to RETENER with counter<=RETENCION-1.
REQ-018 RETENER: Habilitar=0, Hecho=0, Concesion held; decrement the counter each cycle; at counter==0, go to LIBRE and clear Concesion.
REQ-019 A Solicitud change after edge E SHALL NOT abort or alter the transfer; Tupla keeps the data captured at E.
REQ-020 Tupla SHALL hold its last value in LIBRE and RETENER; it is not cleared.
REQ-021 Requests SHALL be sampled only in LIBRE; a requester holds Solicitud until Hecho and deasserts it in the Hecho cycle to avoid re-arbitration.
REQ-022 Throughput: one write per 2+RETENCION cycles under continuous requests.

Reset
REQ-023 Reiniciar low SHALL immediately force state=LIBRE, Concesion=0, Habilitar=0, Tupla=0, Hecho=0, Ocupado=0, counter=0, pointer=3.
REQ-024 Reset asserted in ESCRIBIR SHALL drop Habilitar at once, with no Hecho pulse; that transfer is lost.
REQ-025 After reset release, the first arbitration SHALL favour requester 0.

Configuration
REQ-026 Macro ARBITRO_PRIORIDAD_FIJA_EN defined: fixed priority, lowest set index wins; the pointer is not used for selection.
REQ-027 Macro ARBITRO_PRIORIDAD_FIJA_EN undefined: round-robin selection per REQ-015.

Verification
REQ-028 Reset, then Solicitud=4'b0100 with slice2=4'hA -> after one edge: Concesion=0100, Habilitar=1, Tupla=A, Hecho=0100 for one cycle; then one RETENER cycle; then LIBRE with Concesion=0.
REQ-029 Solicitud=4'b1111 held continuously, RETENCION=1 -> Habilitar pulses every 3 cycles with grants 0001, 0010, 0100, 1000, 0001.
REQ-030 Same stimulus with ARBITRO_PRIORIDAD_FIJA_EN defined -> every grant is 0001.
REQ-031 Reiniciar low during ESCRIBIR -> all outputs are 0 at once, with no Hecho; after release, Solicitud=4'b1001 -> first grant 0001.
REQ-032 Solicitud dropped to 0 during ESCRIBIR -> Hecho still pulses, Tupla keeps the captured value, and the FSM returns to LIBRE normally.
REQ-033 RETENCION=0, Solicitud=4'b1010 held -> grants alternate 0010 and 1000, with Habilitar high every 2nd cycle.
